// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: lap recorder state encoding and the BCD time record
// used for live digits, displayed digits and stored lap entries.
package stopwatch_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    LIVE,
    HOLD,
    RECALL
  } lap_state_t;

  // d0 = ms tens, d1 = ms hundreds, d2 = sec ones, d3 = sec tens
  typedef struct packed {
    logic [BCD_W-1:0] d3;
    logic [BCD_W-1:0] d2;
    logic [BCD_W-1:0] d1;
    logic [BCD_W-1:0] d0;
  } bcd_time_t;

endpackage

// File: rtl/press_detect.sv
// Turns a debounced active-low key level into a single-cycle press pulse.
module press_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  logic prev_n;

  // Remember last cycle's key level; released (1) out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_n <= 1'b1;
    else        prev_n <= btn_n;
  end

  assign press = prev_n & ~btn_n;

endmodule

// File: rtl/lap_recorder.sv
// Lap/split memory: captures live BCD time on lap presses, holds the captured
// value on the display for a while, and lets the user browse laps when paused.
module lap_recorder
  import stopwatch_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lap_btn_n,
  input  logic             recall_btn_n,
  input  logic             counting,
  input  logic             reset_timer,
  input  logic [BCD_W-1:0] live_d0,
  input  logic [BCD_W-1:0] live_d1,
  input  logic [BCD_W-1:0] live_d2,
  input  logic [BCD_W-1:0] live_d3,
  output logic [BCD_W-1:0] disp_d0,
  output logic [BCD_W-1:0] disp_d1,
  output logic [BCD_W-1:0] disp_d2,
  output logic [BCD_W-1:0] disp_d3,
  output logic             showing_lap,
  output logic [2:0]       lap_idx,
  output logic [3:0]       lap_count,
  output logic             overflow
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [3:0]        DEPTH_CNT = 4'(DEPTH);

  lap_state_t        state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_next;
  logic [PTR_W-1:0]  last_ptr, last_ptr_next;
  logic [PTR_W-1:0]  rec_idx, rec_idx_next;
  logic [3:0]        count, count_next;
  logic              ovf, ovf_next;
  logic              counting_q;
  logic              write_en;
  logic              lap_press, recall_press, lap_take;
  bcd_time_t         live_time, shown_time;
  bcd_time_t         buffer [DEPTH];

  press_detect u_lap_press (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (lap_btn_n),
    .press (lap_press)
  );

  press_detect u_recall_press (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (recall_btn_n),
    .press (recall_press)
  );

  assign live_time = '{d3: live_d3, d2: live_d2, d1: live_d1, d0: live_d0};
  assign lap_take  = lap_press & counting;

  // State and bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LIVE;
      hold_cnt   <= '0;
      wr_ptr     <= '0;
      last_ptr   <= '0;
      rec_idx    <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      counting_q <= 1'b0;
    end else begin
      state      <= state_next;
      hold_cnt   <= hold_cnt_next;
      wr_ptr     <= wr_ptr_next;
      last_ptr   <= last_ptr_next;
      rec_idx    <= rec_idx_next;
      count      <= count_next;
      ovf        <= ovf_next;
      counting_q <= counting;
    end
  end

  // Next-state logic; timer clear beats any press, lap capture beats browsing
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    wr_ptr_next   = wr_ptr;
    last_ptr_next = last_ptr;
    rec_idx_next  = rec_idx;
    count_next    = count;
    ovf_next      = ovf;
    write_en      = 1'b0;
    if (reset_timer) begin
      state_next    = LIVE;
      hold_cnt_next = '0;
      wr_ptr_next   = '0;
      rec_idx_next  = '0;
      count_next    = '0;
      ovf_next      = 1'b0;
    end else if (lap_take && state != RECALL) begin
      if (count < DEPTH_CNT) begin
        write_en      = 1'b1;
        last_ptr_next = wr_ptr;
        wr_ptr_next   = wr_ptr + PTR_W'(1);
        count_next    = count + 4'd1;
        hold_cnt_next = HOLD_LOAD;
        state_next    = HOLD;
      end else begin
        ovf_next = 1'b1;
        if (state == HOLD) hold_cnt_next = HOLD_LOAD;
      end
    end else begin
      case (state)
        LIVE: begin
          if (recall_press && !counting && count != 4'd0) begin
            rec_idx_next = '0;
            state_next   = RECALL;
          end
        end
        HOLD: begin
          if (hold_cnt == '0) state_next = LIVE;
          else                hold_cnt_next = hold_cnt - HOLD_W'(1);
        end
        RECALL: begin
          if (counting && !counting_q) begin
            rec_idx_next = '0;
            state_next   = LIVE;
          end else if (recall_press) begin
            if ((4'(rec_idx) + 4'd1) == count) begin
              rec_idx_next = '0;
              state_next   = LIVE;
            end else begin
              rec_idx_next = rec_idx + PTR_W'(1);
            end
          end
        end
        default: state_next = LIVE;
      endcase
    end
  end

  // Lap storage; entries stay until the next timer clear
  always_ff @(posedge clk) begin
    if (write_en) buffer[wr_ptr] <= live_time;
  end

  // Display mux: live time, the freshly captured lap, or the browsed lap
  always_comb begin
    shown_time  = live_time;
    showing_lap = 1'b0;
    lap_idx     = 3'd0;
    case (state)
      HOLD: begin
        shown_time  = buffer[last_ptr];
        showing_lap = 1'b1;
      end
      RECALL: begin
        shown_time  = buffer[rec_idx];
        showing_lap = 1'b1;
        lap_idx     = 3'(rec_idx);
      end
      default: ;
    endcase
  end

  assign disp_d0   = shown_time.d0;
  assign disp_d1   = shown_time.d1;
  assign disp_d2   = shown_time.d2;
  assign disp_d3   = shown_time.d3;
  assign lap_count = count;
  assign overflow  = ovf;

endmodule

// File: tb/tb_lap_recorder.sv
// Scoreboard bench for lap_recorder: stimulus queues expected display state,
// a negedge monitor pops and compares against the outputs.
module tb_lap_recorder;
  import stopwatch_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, lap_btn_n, recall_btn_n, counting, reset_timer;
  logic [3:0] live_d0, live_d1, live_d2, live_d3;
  logic [3:0] disp_d0, disp_d1, disp_d2, disp_d3;
  logic       showing_lap, overflow;
  logic [2:0] lap_idx;
  logic [3:0] lap_count;

  typedef struct packed {
    logic [15:0] disp;
    logic        show;
    logic [2:0]  idx;
    logic [3:0]  cnt;
    logic        ovf;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;

  lap_recorder #(.DEPTH(4), .HOLD_CYCLES(2000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lap_btn_n    (lap_btn_n),
    .recall_btn_n (recall_btn_n),
    .counting     (counting),
    .reset_timer  (reset_timer),
    .live_d0      (live_d0),
    .live_d1      (live_d1),
    .live_d2      (live_d2),
    .live_d3      (live_d3),
    .disp_d0      (disp_d0),
    .disp_d1      (disp_d1),
    .disp_d2      (disp_d2),
    .disp_d3      (disp_d3),
    .showing_lap  (showing_lap),
    .lap_idx      (lap_idx),
    .lap_count    (lap_count),
    .overflow     (overflow)
  );

  // 10 ns display clock
  always #5 clk = ~clk;

  // Monitor: compare every pending expectation on the falling edge
  always @(negedge clk) begin
    obs_t  e;
    obs_t  a;
    string n;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {disp_d3, disp_d2, disp_d1, disp_d0, showing_lap, lap_idx, lap_count, overflow};
      checks++;
      if (a !== e) begin
        failures++;
        $display("[TB] FAIL %s: got disp=%h show=%0d idx=%0d cnt=%0d ovf=%0d, want disp=%h show=%0d idx=%0d cnt=%0d ovf=%0d",
                 n, a.disp, a.show, a.idx, a.cnt, a.ovf, e.disp, e.show, e.idx, e.cnt, e.ovf);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setLive(input logic [15:0] t);
    {live_d3, live_d2, live_d1, live_d0} = t;
  endtask

  task automatic applyStimulus(input logic lap_n, input logic rec_n,
                               input logic cnt, input logic rt);
    lap_btn_n    = lap_n;
    recall_btn_n = rec_n;
    counting     = cnt;
    reset_timer  = rt;
    tick();
  endtask

  task automatic pressLap();
    applyStimulus(1'b0, 1'b1, counting, 1'b0);
    applyStimulus(1'b1, 1'b1, counting, 1'b0);
  endtask

  task automatic pressRecall();
    applyStimulus(1'b1, 1'b0, counting, 1'b0);
    applyStimulus(1'b1, 1'b1, counting, 1'b0);
  endtask

  // Queue an expectation; the monitor checks it at the coming falling edge
  task automatic checkOutput(input string name, input logic [15:0] disp,
                             input logic show, input logic [2:0] idx,
                             input logic [3:0] cnt, input logic ovf);
    exp_q.push_back('{disp: disp, show: show, idx: idx, cnt: cnt, ovf: ovf});
    name_q.push_back(name);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; lap_btn_n = 1'b1; recall_btn_n = 1'b1;
    counting = 1'b0; reset_timer = 1'b0;
    setLive(16'h0000);
    #12;
    setLive(16'h9876);
    checkOutput("reset_state", 16'h9876, 1'b0, 3'd0, 4'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    setLive(16'h4321);
    checkOutput("live_track", 16'h4321, 1'b0, 3'd0, 4'd0, 1'b0);

    // Capture and exact hold length
    counting = 1'b1;
    setLive(16'h1234);
    pressLap();
    checkOutput("cap_show", 16'h1234, 1'b1, 3'd0, 4'd1, 1'b0);
    setLive(16'h5678);
    checkOutput("cap_freeze", 16'h1234, 1'b1, 3'd0, 4'd1, 1'b0);
    repeat (1997) tick();
    checkOutput("hold_last", 16'h1234, 1'b1, 3'd0, 4'd1, 1'b0);
    tick();
    checkOutput("hold_end", 16'h5678, 1'b0, 3'd0, 4'd1, 1'b0);

    // Async reset in the middle of a hold
    setLive(16'h0101);
    pressLap();
    checkOutput("pre_rst", 16'h0101, 1'b1, 3'd0, 4'd2, 1'b0);
    rst_n = 1'b0;
    setLive(16'h0202);
    #1;
    checkOutput("rst_mid_hold", 16'h0202, 1'b0, 3'd0, 4'd0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Five presses into a four-entry buffer
    setLive(16'h0011); pressLap();
    setLive(16'h0022); pressLap();
    setLive(16'h0033); pressLap();
    setLive(16'h0044); pressLap();
    checkOutput("full", 16'h0044, 1'b1, 3'd0, 4'd4, 1'b0);
    setLive(16'h0055); pressLap();
    checkOutput("ovf_set", 16'h0044, 1'b1, 3'd0, 4'd4, 1'b1);
    repeat (2000) tick();
    counting = 1'b0;
    setLive(16'h0999);
    tick();
    checkOutput("ovf_live", 16'h0999, 1'b0, 3'd0, 4'd4, 1'b1);
    pressRecall(); checkOutput("ovf_e0", 16'h0011, 1'b1, 3'd0, 4'd4, 1'b1);
    pressRecall(); checkOutput("ovf_e1", 16'h0022, 1'b1, 3'd1, 4'd4, 1'b1);
    pressRecall(); checkOutput("ovf_e2", 16'h0033, 1'b1, 3'd2, 4'd4, 1'b1);
    pressRecall(); checkOutput("ovf_e3", 16'h0044, 1'b1, 3'd3, 4'd4, 1'b1);
    pressRecall(); checkOutput("ovf_back", 16'h0999, 1'b0, 3'd0, 4'd4, 1'b1);

    // Timer clear coinciding with a lap press
    counting = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("rt_lap", 16'h0999, 1'b0, 3'd0, 4'd0, 1'b0);

    // Recall when empty, lap while paused
    counting = 1'b0;
    pressRecall();
    checkOutput("rec_empty", 16'h0999, 1'b0, 3'd0, 4'd0, 1'b0);
    pressLap();
    checkOutput("lap_paused", 16'h0999, 1'b0, 3'd0, 4'd0, 1'b0);

    // Held key gives one capture, then a three-lap walk
    counting = 1'b1;
    setLive(16'h0130);
    lap_btn_n = 1'b0;
    repeat (5) tick();
    lap_btn_n = 1'b1;
    tick();
    checkOutput("held_once", 16'h0130, 1'b1, 3'd0, 4'd1, 1'b0);
    setLive(16'h0245); pressLap();
    setLive(16'h0360); pressLap();
    checkOutput("three", 16'h0360, 1'b1, 3'd0, 4'd3, 1'b0);
    repeat (2000) tick();
    counting = 1'b0;
    tick();
    checkOutput("walk_live", 16'h0360, 1'b0, 3'd0, 4'd3, 1'b0);
    pressRecall(); checkOutput("walk_0", 16'h0130, 1'b1, 3'd0, 4'd3, 1'b0);
    pressRecall(); checkOutput("walk_1", 16'h0245, 1'b1, 3'd1, 4'd3, 1'b0);
    pressRecall(); checkOutput("walk_2", 16'h0360, 1'b1, 3'd2, 4'd3, 1'b0);
    pressRecall(); checkOutput("walk_end", 16'h0360, 1'b0, 3'd0, 4'd3, 1'b0);

    // Restarting the count leaves recall
    pressRecall();
    checkOutput("rec_again", 16'h0130, 1'b1, 3'd0, 4'd3, 1'b0);
    counting = 1'b1;
    tick();
    checkOutput("count_rise", 16'h0360, 1'b0, 3'd0, 4'd3, 1'b0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lap_recorder.md
# lap_recorder

Lap/split memory between the time counter and the 7-segment driver. It captures the running BCD time on each lap press into a small circular buffer. It freezes the display on the captured value for a hold period, then lets the user step through stored laps while the stopwatch is paused. Its display outputs replace the counter digits on the inputs of the 7-segment driver.

## Interface
- DEPTH, 4: number of lap entries stored (2..8)
- HOLD_CYCLES, 2000: clk cycles a freshly captured lap stays on the display (2 s at the 1 kHz display clock)
- clk  in  1  display clock (clk_display domain); all inputs are synchronous to it
- rst_n  in  1  reset, asynchronous assert, active-low
- lap_btn_n  in  1  debounced lap key, active-low level
- recall_btn_n  in  1  debounced recall key, active-low level
- counting  in  1  FSM counting flag
- reset_timer  in  1  FSM timer-clear pulse/level
- live_d0..live_d3  in  4 each  live BCD digits (ms tens, ms hundreds, sec ones, sec tens)
- disp_d0..disp_d3  out  4 each  digits to the 7-segment driver
- showing_lap  out  1  high when disp_* shows a stored lap, not live time
- lap_idx  out  3  index of the displayed lap (0 = oldest); 0 when live
- lap_count  out  4  number of valid entries, 0..DEPTH
- overflow  out  1  sticky; a lap press was dropped because the buffer was full

## Operation
- Press detection: a press is a registered previous level of 1 with a current level of 0. The registered level resets to 1 (released). Holding a key produces exactly one press.
- States:
  - LIVE: disp = live digits.
  - HOLD: disp = last captured entry; hold counter runs.
  - RECALL: disp = entry lap_idx.
- LIVE transitions:
  - Lap press with counting=1 and lap_count<DEPTH: write live digits at the write pointer, increment the pointer and lap_count, load the hold counter with HOLD_CYCLES-1, go to HOLD.
  - Lap press with counting=1 and lap_count==DEPTH: no write, set overflow, stay LIVE.
  - Lap press with counting=0: ignored.
  - Recall press with counting=0 and lap_count>0: lap_idx=0, go to RECALL.
  - Recall press with counting=0 and lap_count==0: ignored.
- HOLD transitions:
  - Hold counter decrements each cycle; at 0 go to LIVE.
  - Lap press (counting=1): capture a new entry, or set overflow if full, and reload the hold counter.
  - Recall press: ignored.
- RECALL transitions:
  - Recall press: if lap_idx==lap_count-1, go to LIVE with lap_idx=0; otherwise lap_idx+1.
  - counting rising to 1: go to LIVE.
  - Lap press: ignored.
- Simultaneous lap and recall presses: lap has priority when counting=1, recall has priority when counting=0.
- reset_timer=1: synchronous clear of lap_count, write pointer, lap_idx and overflow, state to LIVE. It overrides any press in the same cycle. Buffer contents need not be cleared.
- Buffer is write-once-until-clear, with no overwrite of the oldest entry. Entry i is always the i-th lap since the last clear.

## Timing
- Reset (async, rst_n=0): state LIVE, lap_count 0, lap_idx 0, overflow 0, showing_lap 0, hold counter 0, press registers 1. disp_* then equals live_d*.
- Press sampled at clk edge N: buffer, state and counters update at edge N. disp_*, showing_lap and lap_idx are combinational from registered state and the buffer, so they are valid after edge N. There is no further pipeline.
- HOLD lasts exactly HOLD_CYCLES cycles: showing_lap is high for HOLD_CYCLES clk periods after the capture edge.
- In LIVE, disp_* tracks live_d* combinationally (zero latency).
- Hold counter width: clog2(HOLD_CYCLES). Write pointer width: clog2(DEPTH). lap_count wraps never; it saturates at DEPTH.

## Structure
- Shared package stopwatch_pkg holds:
  - lap_state_t enum {LIVE, HOLD, RECALL}
  - BCD_W = 4
  - bcd_time_t: struct of four BCD digits, used for live, disp and buffer entries
- Sub-module press_detect (register plus falling-edge pulse), instantiated twice.
- Buffer: a register array of bcd_time_t [DEPTH], with no RAM inference required.

## Test plan
- Reset mid-HOLD: assert rst_n=0 with showing_lap=1 -> showing_lap, lap_count and overflow read 0 immediately, and disp=live digits.
- Capture: counting=1, live=12.34 (d3..d0=1,2,3,4), lap press -> disp=1,2,3,4 and showing_lap=1 for exactly 2000 cycles while live advances, then disp=live and lap_count=1.
- Overflow: 5 lap presses with DEPTH=4 -> lap_count=4, overflow=1, and entries 0..3 equal the first four captured times.
- Recall walk: counting=0 with 3 laps stored, 4 recall presses -> lap_idx 0,1,2, then LIVE with showing_lap=0, each step showing the matching stored value.
- Recall when empty, and lap while paused: both are ignored, with the state staying LIVE and lap_count=0.
- reset_timer in the same cycle as a lap press -> lap_count=0, state LIVE, no capture.
